spi_arbiter: RTL and testbench

- Shares one SPI master between two requesters, e.g. a sensor init sequencer (port 0) and a periodic A2D poller (port 1).
- Arbitrates round-robin and launches the winning 16-bit command with a 1-cycle wrt pulse.
- Waits for the master's done, returns rd_data plus a 1-cycle ack to the winner, then enforces a minimum SS_n-high gap.
- Includes a watchdog so a hung transaction cannot lock out either requester.

---
 rtl/spi_arbiter_pkg.sv | 18 +
 rtl/spi_arbiter_if.sv | 30 +++
 rtl/spi_arbiter_rr_pick.sv | 20 ++
 rtl/spi_arbiter.sv | 106 ++++++++++
 tb/tb_spi_arbiter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_arbiter_pkg.sv
// Shared types and defaults for the two-port SPI master arbiter.
package spi_arb_pkg;

  localparam int CMD_W = 16;

  localparam int               GAP_CYCLES_DEF     = 4;
  localparam int               TIMEOUT_CYCLES_DEF = 4096;
  localparam logic [CMD_W-1:0] TIMEOUT_DATA_DEF   = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    RESP,
    GAP
  } arb_state_t;

endpackage

// File: rtl/spi_arbiter_if.sv
// Requester, response and SPI-master signals of the arbiter, bundled with modports.
interface spi_arbiter_if;
  import spi_arb_pkg::*;

  logic             req0;
  logic [CMD_W-1:0] cmd0;
  logic             req1;
  logic [CMD_W-1:0] cmd1;
  logic             ack0;
  logic             ack1;
  logic [CMD_W-1:0] rd_data;
  logic             timeout;
  logic             busy;
  logic             wrt;
  logic [CMD_W-1:0] mstr_cmd;
  logic             mstr_done;
  logic [CMD_W-1:0] mstr_rd_data;

  // slave: the arbiter itself; master: requesters plus the SPI master side
  modport slave (
    input  req0, cmd0, req1, cmd1, mstr_done, mstr_rd_data,
    output ack0, ack1, rd_data, timeout, busy, wrt, mstr_cmd
  );

  modport master (
    output req0, cmd0, req1, cmd1, mstr_done, mstr_rd_data,
    input  ack0, ack1, rd_data, timeout, busy, wrt, mstr_cmd
  );

endinterface

// File: rtl/spi_arbiter_rr_pick.sv
// Combinational two-way round-robin picker: on contention the port that did not win last time wins.
module spi_rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic valid,
  output logic gnt
);

  always_comb begin
    valid = req0 | req1;
    gnt   = 1'b0;
    if (req0 && req1) begin
      gnt = ~last_grant;
    end else if (req1) begin
      gnt = 1'b1;
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one SPI master between two requesters: round-robin grant, launch, wait with watchdog, ack, SS_n gap.
module spi_arbiter
  import spi_arb_pkg::*;
#(
  parameter int               GAP_CYCLES     = GAP_CYCLES_DEF,
  parameter int               TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter logic [CMD_W-1:0] TIMEOUT_DATA   = TIMEOUT_DATA_DEF
) (
  input logic          clk,
  input logic          rst,
  spi_arbiter_if.slave bus
);

  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  GAP_LOAD  = 8'(GAP_CYCLES - 1);

  arb_state_t       state;
  arb_state_t       state_nxt;
  logic             gnt;
  logic             last_grant;
  logic [15:0]      wdog;
  logic [7:0]       gap_cnt;
  logic             to_flag;
  logic [CMD_W-1:0] rd_data_q;
  logic [CMD_W-1:0] mstr_cmd_q;
  logic             pick_vld;
  logic             pick_gnt;
  logic             wdog_expired;

  spi_rr_pick u_pick (
    .req0       (bus.req0),
    .req1       (bus.req1),
    .last_grant (last_grant),
    .valid      (pick_vld),
    .gnt        (pick_gnt)
  );

  assign wdog_expired = (wdog == WDOG_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld) state_nxt = LAUNCH;
      LAUNCH:  state_nxt = WAIT;
      WAIT:    if (bus.mstr_done || wdog_expired) state_nxt = RESP;
      RESP:    state_nxt = GAP;
      GAP:     if (gap_cnt == 8'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Watchdog is zero during the wrt cycle, so expiry lands TIMEOUT_CYCLES clocks after wrt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt        <= 1'b0;
      last_grant <= 1'b1;
      wdog       <= '0;
      gap_cnt    <= '0;
      to_flag    <= 1'b0;
      rd_data_q  <= '0;
      mstr_cmd_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            mstr_cmd_q <= pick_gnt ? bus.cmd1 : bus.cmd0;
            gnt        <= pick_gnt;
            wdog       <= '0;
            to_flag    <= 1'b0;
          end
        end
        LAUNCH: wdog <= wdog + 16'd1;
        WAIT: begin
          if (bus.mstr_done) begin
            rd_data_q <= bus.mstr_rd_data;
          end else if (wdog_expired) begin
            rd_data_q <= TIMEOUT_DATA;
            to_flag   <= 1'b1;
          end else begin
            wdog <= wdog + 16'd1;
          end
        end
        RESP: begin
          last_grant <= gnt;
          gap_cnt    <= GAP_LOAD;
        end
        GAP: if (gap_cnt != 8'd0) gap_cnt <= gap_cnt - 8'd1;
        default: ;
      endcase
    end
  end

  assign bus.wrt      = (state == LAUNCH);
  assign bus.ack0     = (state == RESP) && !gnt;
  assign bus.ack1     = (state == RESP) && gnt;
  assign bus.timeout  = (state == RESP) && to_flag;
  assign bus.busy     = (state != IDLE);
  assign bus.rd_data  = rd_data_q;
  assign bus.mstr_cmd = mstr_cmd_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter with a fixed-latency SPI master model returning ~cmd.
module tb_spi_arbiter;
  import spi_arb_pkg::*;

  localparam int GAP = 4;
  localparam int TO  = 64;
  localparam int LAT = 40;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spi_arbiter_if bus ();

  spi_arbiter #(
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TO),
    .TIMEOUT_DATA   (16'hFFFF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SPI master model: done LAT cycles after wrt, returning the inverted command
  logic        model_done  = 1'b0;
  logic [15:0] model_data  = 16'h0000;
  logic        stray_done  = 1'b0;
  bit          master_hang = 1'b0;
  int          lat         = 0;
  int          done_cyc    = 0;

  assign bus.mstr_done    = model_done | stray_done;
  assign bus.mstr_rd_data = stray_done ? 16'h5A5A : model_data;

  always @(negedge clk) begin
    model_done <= 1'b0;
    if (bus.wrt && !master_hang) begin
      lat        <= LAT;
      model_data <= ~bus.mstr_cmd;
    end else if (lat > 0) begin
      lat <= lat - 1;
      if (lat == 1) begin
        model_done <= 1'b1;
        done_cyc   <= cyc;
      end
    end
  end

  // Transaction log
  int          n_wrt = 0;
  int          n_ack = 0;
  int          wrt_cyc  [64];
  logic [15:0] wrt_cmd  [64];
  int          ack_cyc  [64];
  int          ack_port [64];
  logic [15:0] ack_data [64];
  bit          ack_to   [64];

  always @(negedge clk) begin
    if (bus.wrt) begin
      if (n_wrt < 64) begin
        wrt_cyc[n_wrt] <= cyc;
        wrt_cmd[n_wrt] <= bus.mstr_cmd;
      end
      n_wrt <= n_wrt + 1;
    end
    if (bus.ack0 || bus.ack1) begin
      if (n_ack < 64) begin
        ack_cyc[n_ack]  <= cyc;
        ack_port[n_ack] <= (bus.ack0 && bus.ack1) ? 2 : (bus.ack1 ? 1 : 0);
        ack_data[n_ack] <= bus.rd_data;
        ack_to[n_ack]   <= bus.timeout;
      end
      n_ack <= n_ack + 1;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  task automatic wait_port(input int port, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      step(1);
      if ((port == 0 && bus.ack0) || (port == 1 && bus.ack1)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.cmd0 = 16'h0000; bus.cmd1 = 16'h0000;
    rst = 1'b1;
    step(2);
    checks++;
    if ({bus.wrt, bus.ack0, bus.ack1, bus.timeout, bus.busy} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 00000", {bus.wrt, bus.ack0, bus.ack1, bus.timeout, bus.busy});
    end
    checks++;
    if (bus.rd_data !== 16'h0000 || bus.mstr_cmd !== 16'h0000) begin
      failures++;
      $display("FAIL reset_data: got rd=%h cmd=%h expected 0000/0000", bus.rd_data, bus.mstr_cmd);
    end
    rst = 1'b0;
    step(3);
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_req: got busy=%b expected 0", bus.busy);
    end
  endtask

  task automatic test_single();
    int bw, ba, n;
    bit ok;
    do_reset();
    bw = n_wrt; ba = n_ack;
    bus.cmd0 = 16'hDCBA;
    bus.req0 = 1'b1;
    n = cyc;
    wait_port(0, 200, ok);
    bus.req0 = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL single_ack: got no ack0 expected ack0 within 200 cycles");
    end
    step(10);
    checks++;
    if (n_wrt - bw !== 1 || wrt_cmd[bw] !== 16'hDCBA) begin
      failures++;
      $display("FAIL single_wrt: got %0d wrt cmd=%h expected 1 wrt cmd=dcba", n_wrt - bw, wrt_cmd[bw]);
    end
    checks++;
    if (wrt_cyc[bw] !== n + 1) begin
      failures++;
      $display("FAIL single_grant_lat: got wrt cycle %0d expected %0d", wrt_cyc[bw], n + 1);
    end
    checks++;
    if (ack_cyc[ba] !== done_cyc + 1 || ack_cyc[ba] - wrt_cyc[bw] !== LAT + 1) begin
      failures++;
      $display("FAIL single_ack_lat: got ack cycle %0d expected %0d", ack_cyc[ba], wrt_cyc[bw] + LAT + 1);
    end
    checks++;
    if (ack_data[ba] !== 16'h2345 || bus.rd_data !== 16'h2345) begin
      failures++;
      $display("FAIL single_data: got ack=%h held=%h expected 2345", ack_data[ba], bus.rd_data);
    end
    checks++;
    if (n_ack - ba !== 1 || ack_port[ba] !== 0 || ack_to[ba] !== 1'b0) begin
      failures++;
      $display("FAIL single_port: got %0d acks port=%0d to=%b expected 1 ack port=0 to=0", n_ack - ba, ack_port[ba], ack_to[ba]);
    end
  endtask

  task automatic test_simultaneous();
    int bw, ba;
    bit ok0, ok1;
    do_reset();
    bw = n_wrt; ba = n_ack;
    bus.cmd0 = 16'hDEAD; bus.cmd1 = 16'hBEEF;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    wait_port(0, 200, ok0);
    bus.req0 = 1'b0;
    wait_port(1, 200, ok1);
    bus.req1 = 1'b0;
    step(8);
    checks++;
    if (!ok0 || !ok1 || n_ack - ba !== 2) begin
      failures++;
      $display("FAIL simul_acks: got ok0=%b ok1=%b n=%0d expected 1 1 2", ok0, ok1, n_ack - ba);
    end
    checks++;
    if (ack_port[ba] !== 0 || ack_port[ba+1] !== 1) begin
      failures++;
      $display("FAIL simul_order: got %0d,%0d expected 0,1", ack_port[ba], ack_port[ba+1]);
    end
    checks++;
    if (wrt_cmd[bw] !== 16'hDEAD || wrt_cmd[bw+1] !== 16'hBEEF) begin
      failures++;
      $display("FAIL simul_cmds: got %h,%h expected dead,beef", wrt_cmd[bw], wrt_cmd[bw+1]);
    end
    checks++;
    if (ack_data[ba] !== 16'h2152 || ack_data[ba+1] !== 16'h4110) begin
      failures++;
      $display("FAIL simul_data: got %h,%h expected 2152,4110", ack_data[ba], ack_data[ba+1]);
    end
    checks++;
    if (wrt_cyc[bw+1] - ack_cyc[ba] !== GAP + 2) begin
      failures++;
      $display("FAIL simul_gap: got %0d cycles ack0->wrt expected %0d", wrt_cyc[bw+1] - ack_cyc[ba], GAP + 2);
    end
  endtask

  task automatic test_fairness();
    int bw, ba;
    bit done6;
    do_reset();
    bw = n_wrt; ba = n_ack;
    bus.cmd0 = 16'h1111; bus.cmd1 = 16'h2222;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    done6 = 1'b0;
    for (int i = 0; i < 600; i++) begin
      step(1);
      if (n_ack - ba >= 6) begin
        done6 = 1'b1;
        break;
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    step(12);
    checks++;
    if (!done6 || n_ack - ba !== 6) begin
      failures++;
      $display("FAIL fair_count: got %0d acks expected 6", n_ack - ba);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (ack_port[ba+i] !== (i % 2) || wrt_cmd[bw+i] !== ((i % 2) ? 16'h2222 : 16'h1111)) begin
        failures++;
        $display("FAIL fair_alt[%0d]: got port=%0d cmd=%h expected port=%0d", i, ack_port[ba+i], wrt_cmd[bw+i], i % 2);
      end
    end
  endtask

  task automatic test_timeout();
    int bw, ba;
    bit ok;
    do_reset();
    bw = n_wrt; ba = n_ack;
    master_hang = 1'b1;
    bus.cmd0 = 16'hA5A5;
    bus.req0 = 1'b1;
    wait_port(0, 200, ok);
    bus.req0 = 1'b0;
    checks++;
    if (!ok || bus.timeout !== 1'b1) begin
      failures++;
      $display("FAIL to_pulse: got ack=%b timeout=%b expected 1 1", ok, bus.timeout);
    end
    checks++;
    if (bus.rd_data !== 16'hFFFF) begin
      failures++;
      $display("FAIL to_data: got %h expected ffff", bus.rd_data);
    end
    step(1);
    checks++;
    if (ack_cyc[ba] - wrt_cyc[bw] !== TO || bus.timeout !== 1'b0) begin
      failures++;
      $display("FAIL to_timing: got %0d cycles timeout_now=%b expected %0d 0", ack_cyc[ba] - wrt_cyc[bw], bus.timeout, TO);
    end
    master_hang = 1'b0;
    bus.cmd1 = 16'h1234;
    bus.req1 = 1'b1;
    wait_port(1, 200, ok);
    bus.req1 = 1'b0;
    checks++;
    if (!ok || bus.rd_data !== 16'hEDCB || bus.timeout !== 1'b0) begin
      failures++;
      $display("FAIL to_recover: got ack=%b rd=%h to=%b expected 1 edcb 0", ok, bus.rd_data, bus.timeout);
    end
    step(8);
  endtask

  task automatic test_reset_mid();
    int ba;
    bit ok;
    do_reset();
    bus.cmd0 = 16'h0F0F;
    bus.req0 = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (bus.wrt) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rmid_wrt: got no wrt expected wrt within 20 cycles");
    end
    step(10);
    ba = n_ack;
    rst = 1'b1;
    bus.req0 = 1'b0;
    #1;
    checks++;
    if ({bus.wrt, bus.ack0, bus.ack1, bus.timeout, bus.busy} !== 5'b0 ||
        bus.rd_data !== 16'h0000 || bus.mstr_cmd !== 16'h0000) begin
      failures++;
      $display("FAIL rmid_async: got ctrl=%b rd=%h cmd=%h expected all zero",
               {bus.wrt, bus.ack0, bus.ack1, bus.timeout, bus.busy}, bus.rd_data, bus.mstr_cmd);
    end
    step(2);
    rst = 1'b0;
    step(45);
    checks++;
    if (n_ack !== ba || bus.busy !== 1'b0 || bus.rd_data !== 16'h0000) begin
      failures++;
      $display("FAIL rmid_late_done: got acks=%0d busy=%b rd=%h expected 0 0 0000", n_ack - ba, bus.busy, bus.rd_data);
    end
    bus.cmd0 = 16'h00FF;
    bus.req0 = 1'b1;
    wait_port(0, 200, ok);
    bus.req0 = 1'b0;
    checks++;
    if (!ok || bus.rd_data !== 16'hFF00 || bus.mstr_cmd !== 16'h00FF) begin
      failures++;
      $display("FAIL rmid_recover: got ack=%b rd=%h cmd=%h expected 1 ff00 00ff", ok, bus.rd_data, bus.mstr_cmd);
    end
    step(8);
  endtask

  task automatic test_stray_done();
    int bw, ba;
    bit ok;
    bw = n_wrt; ba = n_ack;
    stray_done = 1'b1;
    step(1);
    stray_done = 1'b0;
    step(2);
    checks++;
    if (n_ack !== ba || n_wrt !== bw || bus.rd_data !== 16'hFF00 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL stray_idle: got acks=%0d wrts=%0d rd=%h busy=%b expected 0 0 ff00 0",
               n_ack - ba, n_wrt - bw, bus.rd_data, bus.busy);
    end
    bus.cmd0 = 16'h3C3C;
    bus.req0 = 1'b1;
    wait_port(0, 200, ok);
    bus.req0 = 1'b0;
    step(1);
    stray_done = 1'b1;
    step(1);
    stray_done = 1'b0;
    checks++;
    if (!ok || n_ack !== ba + 1 || bus.rd_data !== 16'hC3C3 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL stray_gap: got ok=%b acks=%0d rd=%h busy=%b expected 1 1 c3c3 1",
               ok, n_ack - ba, bus.rd_data, bus.busy);
    end
    step(2);
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL stray_gap_len: got busy=%b expected 1 at gap end", bus.busy);
    end
    step(1);
    checks++;
    if (bus.busy !== 1'b0 || n_wrt !== bw + 1) begin
      failures++;
      $display("FAIL stray_idle_after: got busy=%b wrts=%0d expected 0 1", bus.busy, n_wrt - bw);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_timeout();
    test_reset_mid();
    test_stray_done();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time bound");
    $fatal(1, "time bound expired");
  end

endmodule
